alu_pipe: RTL and testbench

- Parametrised successor to the core ALU.
- Takes operands through a valid/ready handshake and produces a registered result and condition flags.
- Single-cycle ops (logic, barrel shift, add/sub) complete in 1 cycle. An optional iterative multiplier occupies the block for WIDTH cycles.
- Sits between decode/operand-read and writeback. Downstream can apply backpressure.

---
 rtl/alu_pipe_pkg.sv | 19 +
 rtl/alu_mul_iter.sv | 53 +++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared opcode and state definitions for alu_pipe and its iterative multiplier.
package alu_pipe_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned WIDTH x WIDTH shift-add multiplier: one partial product per cycle after start.
// done is asserted during the final iteration; product is the accumulator including that iteration.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               busy;

    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
        done    = busy && (cnt == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; optional iterative multiply when
// ALU_PIPE_MUL_EN is defined (otherwise opcode 111 returns 0 in one cycle).
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_inValid,
    output logic             o_inReady,
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [2:0]       i_opcode,
    input  logic             i_flagBit,
    output logic             o_outValid,
    input  logic             i_outReady,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_carry,
    output logic             o_overflow
);

    state_t             state;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic               sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum;
    logic               add_c;
    logic [WIDTH-1:0]   sra;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c;
    logic               ovf_c;

    assign o_inReady = (state == ST_IDLE) || ((state == ST_DONE) && i_outReady);
    assign accept    = i_inValid && o_inReady;

    always_comb begin
        shamt          = i_src2[SHAMT_W-1:0];
        sub            = (i_opcode == OP_SUB);
        b_eff          = sub ? ~i_src2 : i_src2;
        {add_c, sum}   = {1'b0, i_src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        // kept separate so the signed shift is not demoted to logical by a mixed-sign ternary
        sra            = $unsigned($signed(i_src1) >>> shamt);
        res_c          = '0;
        carry_c        = 1'b0;
        ovf_c          = 1'b0;
        case (i_opcode)
            OP_AND: res_c = i_src1 & i_src2;
            OP_OR:  res_c = i_src1 | i_src2;
            OP_XOR: res_c = i_src1 ^ i_src2;
            OP_SHL: res_c = i_src1 << shamt;
            OP_SHR: res_c = i_flagBit ? sra : (i_src1 >> shamt);
            OP_ADD, OP_SUB: begin
                res_c   = sum;
                carry_c = add_c;
                ovf_c   = (i_src1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != i_src1[WIDTH-1]);
            end
            default: res_c = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic                 mul_hi;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     mul_res;

    assign mul_start = accept && (i_opcode == OP_MUL);
    assign mul_res   = mul_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .start   (mul_start),
        .a       (i_src1),
        .b       (i_src2),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            o_outValid <= 1'b0;
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_neg      <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            mul_hi     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        // with the multiplier enabled, MUL diverts to BUSY; all else registers now
`ifdef ALU_PIPE_MUL_EN
                        if (i_opcode == OP_MUL) begin
                            state      <= ST_BUSY;
                            o_outValid <= 1'b0;
                            mul_hi     <= i_flagBit;
                        end else
`endif
                        begin
                            state      <= ST_DONE;
                            o_outValid <= 1'b1;
                            o_result   <= res_c;
                            o_zero     <= (res_c == '0);
                            o_neg      <= res_c[WIDTH-1];
                            o_carry    <= carry_c;
                            o_overflow <= ovf_c;
                        end
                    end else if ((state == ST_DONE) && i_outReady) begin
                        state      <= ST_IDLE;
                        o_outValid <= 1'b0;
                    end
                end
`ifdef ALU_PIPE_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state      <= ST_DONE;
                        o_outValid <= 1'b1;
                        o_result   <= mul_res;
                        o_zero     <= (mul_res == '0);
                        o_neg      <= mul_res[WIDTH-1];
                        o_carry    <= 1'b0;
                        o_overflow <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    o_outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed cases, randomized ops against
// an arithmetic reference model, backpressure, back-to-back issue and reset abort.
module tb_alu_pipe;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  s1;
    logic [W-1:0]  s2;
    logic [2:0]    opc;
    logic          flag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          neg;
    logic          carry;
    logic          ovf;
    logic [19:0]   obs;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign obs = {result, zero, neg, carry, ovf};

    alu_pipe #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rstn     (rst_n),
        .i_inValid  (in_valid),
        .o_inReady  (in_ready),
        .i_src1     (s1),
        .i_src2     (s2),
        .i_opcode   (opc),
        .i_flagBit  (flag),
        .o_outValid (out_valid),
        .i_outReady (out_ready),
        .o_result   (result),
        .o_zero     (zero),
        .o_neg      (neg),
        .o_carry    (carry),
        .o_overflow (ovf)
    );

    // Reference: {result, zero, neg, carry, overflow} from plain integer arithmetic.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic f);
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [31:0] wide;
        int          sa;
        int          sb;
        int          s;
        int          sh;
        sa = a[15] ? int'(a) - 65536 : int'(a);
        sb = b[15] ? int'(b) - 65536 : int'(b);
        sh = int'(b) % 16;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: begin wide = 32'(a) << sh; r = wide[15:0]; end
            3'd4: r = (a >> sh) | ((f && a[15]) ? ~(16'hFFFF >> sh) : 16'h0000);
            3'd5: begin
                wide = 32'(a) + 32'(b);
                r = wide[15:0];
                c = wide[16];
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            3'd6: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            default: begin
                wide = 32'(a) * 32'(b);
                r = MUL_EN ? (f ? wide[31:16] : wide[15:0]) : 16'h0000;
            end
        endcase
        return {r, (r == 16'h0000), r[15], c, v};
    endfunction

    // Drives one operation through the handshake and reports the observed timing/outputs.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic f,
                         output int stall, output int lat, output int lowcnt, output logic [19:0] got);
        opc = op; s1 = a; s2 = b; flag = f;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        stall = 0;
        while (!in_ready && stall < 100) begin
            @(posedge clk); #1;
            stall++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        s1 = 16'($urandom); s2 = 16'($urandom); flag = 1'($urandom); opc = 3'($urandom);
        lat = 1;
        lowcnt = in_ready ? 0 : 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!in_ready) lowcnt++;
        end
        got = obs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s1 = '0; s2 = '0; opc = '0; flag = 1'b0;
        #12;
        checks++;
        if ({out_valid, obs} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b obs=%h exp valid=0 obs=00000", out_valid, obs);
        end
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [8] = '{3'd5, 3'd6, 3'd6, 3'd4, 3'd4, 3'd3, 3'd3, 3'd5};
        logic [15:0] aa   [8] = '{16'h7FFF, 16'h0003, 16'h0005, 16'h8010, 16'h8010, 16'h0001, 16'h1234, 16'hFFFF};
        logic [15:0] bb   [8] = '{16'h0001, 16'h0005, 16'h0005, 16'h0014, 16'h0014, 16'h000F, 16'h0010, 16'h0001};
        logic        ff   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [19:0] exp  [8] = '{{16'h8000, 4'b0101}, {16'hFFFE, 4'b0100}, {16'h0000, 4'b1010},
                                  {16'hF801, 4'b0100}, {16'h0801, 4'b0000}, {16'h8000, 4'b0100},
                                  {16'h1234, 4'b0000}, {16'h0000, 4'b1010}};
        int stall, lat, lowcnt;
        logic [19:0] got;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], aa[i], bb[i], ff[i], stall, lat, lowcnt, got);
            checks++;
            if (got !== exp[i]) begin
                failures++;
                $display("FAIL directed_%0d got=%h exp=%h", i, got, exp[i]);
            end
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL directed_lat_%0d got=%0d exp=1", i, lat);
            end
        end
    endtask

    task automatic test_mul();
        int stall, lat, lowcnt;
        logic [19:0] got;
        for (int i = 0; i < 2; i++) begin
            issue(3'd7, 16'h1234, 16'h0100, 1'(i), stall, lat, lowcnt, got);
            checks++;
            if (got !== (MUL_EN ? (i == 0 ? {16'h3400, 4'b0000} : {16'h0012, 4'b0000}) : {16'h0000, 4'b1000})) begin
                failures++;
                $display("FAIL mul_result_%0d got=%h", i, got);
            end
            checks++;
            if (lat !== (MUL_EN ? W + 1 : 1)) begin
                failures++;
                $display("FAIL mul_latency_%0d got=%0d exp=%0d", i, lat, MUL_EN ? W + 1 : 1);
            end
            checks++;
            if (lowcnt !== (MUL_EN ? W : 0)) begin
                failures++;
                $display("FAIL mul_ready_low_%0d got=%0d exp=%0d", i, lowcnt, MUL_EN ? W : 0);
            end
        end
    endtask

    task automatic test_random();
        int stall, lat, lowcnt;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        f;
        logic [19:0] got, exp;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom); b = 16'($urandom); f = 1'($urandom);
            if (i % 8 == 0) a = 16'h8000;
            exp = model(op, a, b, f);
            issue(op, a, b, f, stall, lat, lowcnt, got);
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h f=%b got=%h exp=%h", i, op, a, b, f, got, exp);
            end
            checks++;
            if (lat !== ((op == 3'd7 && MUL_EN) ? W + 1 : 1)) begin
                failures++;
                $display("FAIL random_lat_%0d op=%0d got=%0d", i, op, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int stall, lat, lowcnt;
        logic [2:0]  op;
        logic [15:0] a, b;
        logic        f;
        logic [19:0] got, exp;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 6));
            a = 16'($urandom); b = 16'($urandom); f = 1'($urandom);
            exp = model(op, a, b, f);
            issue(op, a, b, f, stall, lat, lowcnt, got);
            checks++;
            if ({stall, lat} !== {32'd0, 32'd1}) begin
                failures++;
                $display("FAIL b2b_timing_%0d got stall=%0d lat=%0d exp stall=0 lat=1", i, stall, lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL b2b_data_%0d got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int stall, lat, lowcnt;
        logic [19:0] got, held;
        issue(3'd0, 16'hA5F0, 16'h0FF0, 1'b0, stall, lat, lowcnt, got);
        held = {16'h05F0, 4'b0000};
        checks++;
        if (got !== held) begin
            failures++;
            $display("FAIL bp_and got=%h exp=%h", got, held);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; opc = 3'd2; s1 = 16'h1234; s2 = 16'h00FF; flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({out_valid, in_ready, obs} !== {2'b10, held}) begin
                failures++;
                $display("FAIL bp_hold_%0d got v=%b r=%b obs=%h exp v=1 r=0 obs=%h", i, out_valid, in_ready, obs, held);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_follow got=%b exp=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, obs} !== {1'b1, 16'h12CB, 4'b0000}) begin
            failures++;
            $display("FAIL bp_next_op got v=%b obs=%h exp v=1 obs=12cb0", out_valid, obs);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_drain got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int stall, lat, lowcnt, pulses;
        logic [19:0] got;
        out_ready = 1'b1;
        if (MUL_EN) begin
            opc = 3'd7; s1 = 16'hFFFF; s2 = 16'hFFFF; flag = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (8) @(posedge clk);
        end else begin
            issue(3'd1, 16'h8421, 16'h0F0F, 1'b0, stall, lat, lowcnt, got);
            out_ready = 1'b0;
            @(posedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, obs} !== 21'd0) begin
            failures++;
            $display("FAIL abort_clear got v=%b obs=%h exp v=0 obs=00000", out_valid, obs);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_quiet got bad_cycles=%0d exp=0", pulses);
        end
        issue(3'd5, 16'h1111, 16'h2222, 1'b0, stall, lat, lowcnt, got);
        checks++;
        if ({lat, got} !== {32'd1, 16'h3333, 4'b0000}) begin
            failures++;
            $display("FAIL abort_followup got lat=%0d obs=%h exp lat=1 obs=33330", lat, got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
